// File: rtl/l2_data_ram_ctrl.sv
// L2 data array: byte-strobed banked storage behind a valid/ready request port, with a
// post-reset zeroing sweep and a credit-guarded, in-order read response FIFO.
module l2_data_ram_ctrl #(
    parameter int DATA_W  = 256,
    parameter int BANK_W  = 64,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter bit INIT_EN = 1'b1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                req_vld_i,
    output logic                req_rdy_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_strb_i,
    output logic                rsp_vld_o,
    input  logic                rsp_rdy_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                init_done_o
);
    localparam int N_BANKS   = DATA_W / BANK_W;
    localparam int BANK_B    = BANK_W / 8;
    localparam int LAT       = 1 + int'(OUT_REG);
    localparam int RSP_DEPTH = LAT + 1;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RSP_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);

    if (DATA_W % BANK_W != 0) begin : g_chk_data_w
        $error("DATA_W must be a multiple of BANK_W");
    end
    if (BANK_W % 8 != 0) begin : g_chk_bank_w
        $error("BANK_W must be a multiple of 8");
    end

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_addr_q;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W/8-1:0] ram_strb;
    logic [DATA_W-1:0]   ram_rdata;
    logic                rd_acc;
    logic                rsp_pop;
    logic [CNT_W-1:0]    credit_q;
    logic                push_vld;
    logic [DATA_W-1:0]   push_data;

    // NOTE: sequential state uses non-blocking assignments only, and rstn_i is sampled on
    // the clock edge (synchronous reset), so a reset mid-sweep restarts it at address 0.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_addr_q <= init_addr_q + 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_addr  = req_addr_i;
        ram_wdata = req_wdata_i;
        ram_strb  = req_strb_i;
        case (state_q)
            ST_INIT: begin
                if (INIT_EN) begin
                    ram_we    = 1'b1;
                    ram_addr  = init_addr_q;
                    ram_wdata = '0;
                    ram_strb  = '1;
                end
                if (!INIT_EN || init_addr_q == ADDR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: ram_we = req_vld_i & req_rdy_o & req_we_i;
            default: state_d = ST_INIT;
        endcase
    end

    assign init_done_o = (state_q == ST_IDLE);
    assign req_rdy_o   = init_done_o && (credit_q < CREDIT_MAX);
    assign rd_acc      = req_vld_i & req_rdy_o & ~req_we_i;
    assign rsp_pop     = rsp_vld_o & rsp_rdy_i;

    // Credit covers reads still in the pipeline plus FIFO entries, so the FIFO cannot overflow.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            credit_q <= '0;
        end else if (rd_acc && !rsp_pop) begin
            credit_q <= credit_q + 1'b1;
        end else if (!rd_acc && rsp_pop) begin
            credit_q <= credit_q - 1'b1;
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [BANK_W-1:0] mem [DEPTH];
        logic [BANK_B-1:0] bank_strb;
        logic              bank_en;

        assign bank_strb = ram_strb[b*BANK_B +: BANK_B];
        assign bank_en   = ram_we & (|bank_strb);

        // NOTE: storage arrays are never reset; the zeroing sweep is what clears them.
        always_ff @(posedge clk_i) begin
            if (bank_en) begin
                for (int k = 0; k < BANK_B; k++) begin
                    if (bank_strb[k]) begin
                        mem[ram_addr][k*8 +: 8] <= ram_wdata[b*BANK_W + k*8 +: 8];
                    end
                end
            end
        end

        assign ram_rdata[b*BANK_W +: BANK_W] = mem[ram_addr];
    end

    if (OUT_REG) begin : g_out_reg
        logic              rd_vld_q;
        logic [DATA_W-1:0] rd_data_q;

        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                rd_vld_q <= 1'b0;
            end else begin
                rd_vld_q <= rd_acc;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rd_acc) begin
                rd_data_q <= ram_rdata;
            end
        end

        assign push_vld  = rd_vld_q;
        assign push_data = rd_data_q;
    end else begin : g_no_out_reg
        assign push_vld  = rd_acc;
        assign push_data = ram_rdata;
    end

    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;

    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rsp_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_vld, rsp_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // The head is only ever written while it is not the head, so it holds under backpressure.
    assign rsp_vld_o   = (fifo_cnt_q != '0);
    assign rsp_rdata_o = rsp_vld_o ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_l2_data_ram_ctrl.sv
// Bench for l2_data_ram_ctrl: directed and random requests against a word-array reference
// model; expected read data is queued at accept and checked by an independent monitor.
module tb_l2_data_ram_ctrl;
    localparam int DATA_W  = 256;
    localparam int BANK_W  = 64;
    localparam int DEPTH   = 512;
    localparam int ADDR_W  = 9;
    localparam int STRB_W  = DATA_W / 8;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 200;

    logic                clk_i = 1'b0;
    logic                rstn_i;
    logic                req_vld_i;
    logic                req_rdy_o;
    logic                req_we_i;
    logic [ADDR_W-1:0]   req_addr_i;
    logic [DATA_W-1:0]   req_wdata_i;
    logic [STRB_W-1:0]   req_strb_i;
    logic                rsp_vld_o;
    logic                rsp_rdy_i;
    logic [DATA_W-1:0]   rsp_rdata_o;
    logic                init_done_o;

    always #5 clk_i = ~clk_i;

    l2_data_ram_ctrl #(
        .DATA_W (DATA_W),
        .BANK_W (BANK_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .INIT_EN(1'b1),
        .OUT_REG(1'b1)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .req_vld_i  (req_vld_i),
        .req_rdy_o  (req_rdy_o),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_strb_i (req_strb_i),
        .rsp_vld_o  (rsp_vld_o),
        .rsp_rdy_i  (rsp_rdy_i),
        .rsp_rdata_o(rsp_rdata_o),
        .init_done_o(init_done_o)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                acc_cyc;
        bit                chk_lat;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    int                rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit                lat_mode = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc++;

    initial begin
        rsp_rdy_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       rsp_rdy_i = 1'b0;
                1:       rsp_rdy_i = 1'b1;
                default: rsp_rdy_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Response monitor: pops the scoreboard on every handshake and checks output hold.
    logic [DATA_W-1:0] held_data;
    bit                held = 1'b0;

    always @(negedge clk_i) begin : mon
        exp_t e;
        if (held && rstn_i) begin
            check("rsp_hold_vld", rsp_vld_o, 1);
            check("rsp_hold_data", rsp_rdata_o, held_data);
        end
        held      = rstn_i && rsp_vld_o && !rsp_rdy_i;
        held_data = rsp_rdata_o;
        if (rstn_i && rsp_vld_o && rsp_rdy_i) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_vld_o, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_rdata_o, e.data);
                if (e.chk_lat) begin
                    check("rsp_latency", cyc - e.acc_cyc, LAT);
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) begin
            w[i*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
    task automatic send(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
        int waited = 0;
        bit ok = 1'b0;
        req_vld_i   = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = data;
        req_strb_i  = strb;
        while (!ok && waited <= TIMEOUT) begin
            @(negedge clk_i);
            if (req_rdy_o === 1'b1) begin
                ok = 1'b1;
            end else begin
                waited++;
                @(posedge clk_i);
                #2;
            end
        end
        if (!ok) begin
            check("req_accept_timeout", req_rdy_o, 1);
        end else if (we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (strb[k]) ref_mem[addr][k*8 +: 8] = data[k*8 +: 8];
            end
        end else begin
            exp_q.push_back('{data: ref_mem[addr], acc_cyc: cyc, chk_lat: lat_mode});
        end
        if (ok) begin
            @(posedge clk_i);
            #2;
        end
        req_vld_i = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < TIMEOUT) begin
            @(posedge clk_i);
            #2;
            w++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic apply_reset(input int hold);
        rstn_i    = 1'b0;
        req_vld_i = 1'b0;
        idle(hold);
        @(negedge clk_i);
        check("rst_req_rdy", req_rdy_o, 0);
        check("rst_rsp_vld", rsp_vld_o, 0);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        check("rst_init_done", init_done_o, 0);
        @(posedge clk_i);
        #2;
        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        rstn_i = 1'b1;
    endtask

    // Entered at cycle 0 after release: busy through cycle DEPTH-1, ready at cycle DEPTH.
    task automatic check_init_sweep();
        int early = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_i);
            if (req_rdy_o !== 1'b0 || init_done_o !== 1'b0) early++;
        end
        check("init_busy_cycles", early, 0);
        @(negedge clk_i);
        check("init_done_at_depth", init_done_o, 1);
        check("req_rdy_at_depth", req_rdy_o, 1);
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [STRB_W-1:0] s;
        rstn_i      = 1'b0;
        req_vld_i   = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_strb_i  = '0;
        @(posedge clk_i);
        #2;

        // Reset values, init sweep timing, swept word reads as zero.
        apply_reset(3);
        check_init_sweep();
        lat_mode = 1'b1;
        send(1'b0, 9'h1FF, '0, '0);
        drain();

        // Byte-strobed partial write merges into the existing word.
        send(1'b1, 9'h010, {8{32'hA5A5A5A5}}, '1);
        send(1'b1, 9'h010, {{7{32'h0}}, 32'hDEADBEEF}, 32'h0000000F);
        send(1'b0, 9'h010, '0, '0);
        drain();

        // Zero-strobe write is a no-op; read on the very next cycle sees new data.
        send(1'b1, 9'h020, rand_word(), '1);
        send(1'b1, 9'h020, rand_word(), '0);
        send(1'b0, 9'h020, '0, '0);
        send(1'b1, 9'h020, rand_word(), '1);
        send(1'b0, 9'h020, '0, '0);
        drain();

        // Back-to-back reads at full throughput with exact latency.
        for (int i = 0; i < 8; i++) send(1'b1, ADDR_W'(i), rand_word(), '1);
        idle(2);
        for (int i = 0; i < 8; i++) send(1'b0, ADDR_W'(i), '0, '0);
        drain();

        // Backpressure: three reads fill the credits, request port stalls, then recovers.
        lat_mode = 1'b0;
        rdy_mode = 0;
        idle(2);
        for (int i = 1; i <= 3; i++) send(1'b0, ADDR_W'(i), '0, '0);
        req_vld_i  = 1'b1;
        req_we_i   = 1'b0;
        req_addr_i = 9'h004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("rdy_low_when_full", req_rdy_o, 0);
            check("rsp_vld_when_full", rsp_vld_o, 1);
            @(posedge clk_i);
            #2;
        end
        rdy_mode = 1;
        send(1'b0, 9'h004, '0, '0);
        drain();

        // Random mix of reads/writes/strobes with random response backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                a = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 15))
                                                : ADDR_W'(9'h1F0 + $urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       s = '1;
                    1:       s = '0;
                    default: s = $urandom();
                endcase
                send($urandom_range(0, 1) != 0, a, rand_word(), s);
            end
        end
        rdy_mode = 1;
        drain();

        // Reset pulse at cycle 100 of the sweep restarts it from address 0.
        apply_reset(2);
        idle(100);
        rstn_i = 1'b0;
        idle(1);
        rstn_i = 1'b1;
        check_init_sweep();
        lat_mode = 1'b1;
        send(1'b0, 9'h010, '0, '0);
        send(1'b0, 9'h1F5, '0, '0);
        send(1'b0, 9'h1FF, '0, '0);
        drain();

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
